// File: rtl/lsu_dmem_master_if.sv
// lsu_dmem_master_if: request, response and data-memory signals of the LSU data-memory port.
//
// Parameters:
//   XLEN        data width (32 only; XLEN/8 byte lanes)
//   ADDR_WIDTH  dmem word-address width
//
// Signal groups:
//   req_*   MEM stage -> LSU: valid/ready handshake, store flag, funct3, byte address, store data
//   resp_*  LSU -> MEM stage: valid/ready handshake, extended load data, error flag
//   mem_*   LSU <-> dmem: write enable, byte enables, word address, write data, registered read data
//
// Modports:
//   master  the LSU (drives req_ready, resp_*, mem_we/byteEnable/address/wd)
//   slave   the environment (drives req_*, resp_ready, mem_rd)

interface lsu_dmem_master_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [XLEN-1:0]       req_addr;
    logic [XLEN-1:0]       req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [XLEN-1:0]       resp_rdata;
    logic                  resp_error;

    logic                  mem_we;
    logic [XLEN/8-1:0]     mem_byteEnable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [XLEN-1:0]       mem_wd;
    logic [XLEN-1:0]       mem_rd;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_we, mem_byteEnable, mem_address, mem_wd
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_we, mem_byteEnable, mem_address, mem_wd
    );
endinterface

// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: initiator side of the data-memory port.
//
// Takes one load/store at a time from the MEM stage, drives dmem (we, byte enables, word address,
// lane-replicated write data) and turns the registered dmem read data into an extracted,
// sign/zero-extended load result.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    lsu_dmem_master_if.master (req_*, resp_*, mem_* groups)
//
// Flow: IDLE -> ISSUE -> CAPTURE -> RESP (load), IDLE -> ISSUE -> RESP (store),
//       IDLE -> RESP (error). Accept-to-resp_valid latency is 3 / 2 / 1 cycles.
//
// Build option: define MISALIGN_TRAP_EN to report misaligned H/W accesses as errors.
// Without it the offset bits are cleared to the natural container and the access proceeds.

module lsu_dmem_master #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input logic               clk,
    input logic               reset,
    lsu_dmem_master_if.master bus
);

    localparam int unsigned NumLanes = XLEN / 8;

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

    state_e                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]       resp_rdata_q, resp_rdata_d;
    logic                  resp_error_q, resp_error_d;
    logic                  mem_we_q, mem_we_d;
    logic [NumLanes-1:0]   mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [XLEN-1:0]       mem_wd_q, mem_wd_d;
    logic                  write_q, write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            off_q, off_d;

    // Request decode (combinational view of the incoming request)
    logic [1:0]          off_raw;
    logic [1:0]          off_eff;
    logic                illegal;
    logic                req_err;
    logic [NumLanes-1:0] be_calc;
    logic [XLEN-1:0]     wd_calc;

    // Load extraction
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_val;

    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[XLEN-1:ADDR_WIDTH+2];

    assign off_raw = bus.req_addr[1:0];

    always_comb begin
        illegal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = bus.req_write;  // unsigned forms are loads only
            default:                illegal = 1'b1;
        endcase
    end

    // Offset snapped to the natural container; only matters when misalignment is not trapped.
    always_comb begin
        off_eff = off_raw;
        case (bus.req_funct3[1:0])
            2'b01:   off_eff = {off_raw[1], 1'b0};
            2'b10:   off_eff = 2'b00;
            default: off_eff = off_raw;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((bus.req_funct3[1:0] == 2'b01) && off_raw[0])
                     || ((bus.req_funct3[1:0] == 2'b10) && (off_raw != 2'b00));
    assign req_err    = illegal | misaligned;
`else
    assign req_err    = illegal;
`endif

    always_comb begin
        be_calc = '0;
        wd_calc = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                be_calc = 4'b0001 << off_eff;
                wd_calc = {(XLEN/8){bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be_calc = 4'b0011 << off_eff;
                wd_calc = {(XLEN/16){bus.req_wdata[15:0]}};
            end
            default: begin
                be_calc = '1;
                wd_calc = bus.req_wdata;
            end
        endcase
    end

    assign shifted = bus.mem_rd >> {off_q, 3'b000};

    always_comb begin
        load_val = shifted;
        case (funct3_q)
            3'b000:  load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        resp_error_d  = resp_error_q;
        mem_we_d      = 1'b0;  // write strobe and byte enables live for the ISSUE cycle only
        mem_be_d      = '0;
        mem_address_d = mem_address_q;
        mem_wd_d      = mem_wd_q;
        write_d       = write_q;
        funct3_d      = funct3_q;
        off_d         = off_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    req_ready_d = 1'b0;
                    write_d     = bus.req_write;
                    funct3_d    = bus.req_funct3;
                    off_d       = off_eff;
                    if (req_err) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d       = StIssue;
                        mem_we_d      = bus.req_write;
                        mem_be_d      = be_calc;
                        mem_address_d = bus.req_addr[ADDR_WIDTH+1:2];
                        if (bus.req_write) begin
                            mem_wd_d = wd_calc;
                        end
                    end
                end
            end
            StIssue: begin
                if (write_q) begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = '0;
                end else begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                state_d      = StResp;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_rdata_d = load_val;
            end
            StResp: begin
                if (bus.resp_ready) begin
                    state_d      = StIdle;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_error_d = 1'b0;
                    resp_rdata_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_error_q  <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_be_q      <= '0;
            mem_address_q <= '0;
            mem_wd_q      <= '0;
            write_q       <= 1'b0;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_error_q  <= resp_error_d;
            mem_we_q      <= mem_we_d;
            mem_be_q      <= mem_be_d;
            mem_address_q <= mem_address_d;
            mem_wd_q      <= mem_wd_d;
            write_q       <= write_d;
            funct3_q      <= funct3_d;
            off_q         <= off_d;
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_error     = resp_error_q;
    // Gated so a store whose ISSUE cycle coincides with reset never reaches dmem.
    assign bus.mem_we         = mem_we_q & ~reset;
    assign bus.mem_byteEnable = mem_be_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_wd         = mem_wd_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: directed bench for lsu_dmem_master with a byte-level reference model,
// a registered-read dmem behind the port, a per-cycle compare process and literal checks.

module tb_lsu_dmem_master;

    logic clk;
    logic reset;
    logic mem_clear;
    logic chk_en;

    int n_tests;
    int n_fail;

    lsu_dmem_master_if #(.XLEN(32), .ADDR_WIDTH(8)) bus ();

    lsu_dmem_master #(.XLEN(32), .ADDR_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem: registered read, byte-enabled write
    logic [31:0] dmem [0:255];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
        end else if (bus.mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_byteEnable[i]) dmem[bus.mem_address][8*i +: 8] <= bus.mem_wd[8*i +: 8];
            end
        end
        bus.mem_rd <= dmem[bus.mem_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one transaction timeline, byte-addressed memory image.
    logic [7:0]  ref_mem [0:1023];
    bit          m_busy;
    int          m_age;
    int          m_lat;
    bit          m_write;
    bit          m_err;
    logic [31:0] m_rdata;
    logic [3:0]  m_be;
    logic [31:0] m_wd;
    logic [7:0]  m_addr;
    int unsigned m_sz, m_off, m_word;
    logic [31:0] m_wdata;

    task automatic model_accept();
        logic [2:0]  f;
        logic [31:0] a, v;
        int unsigned ea;
        bit          legal;
        f       = bus.req_funct3;
        a       = bus.req_addr;
        m_wdata = bus.req_wdata;
        m_write = bus.req_write;
        m_sz    = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        legal   = m_write ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
        m_err   = !legal;
`ifdef MISALIGN_TRAP_EN
        if ((a % m_sz) != 0) m_err = 1'b1;
`endif
        ea     = a - (a % m_sz);
        m_word = (ea / 4) % 256;
        m_off  = ea % 4;
        m_addr = 8'(m_word);
        m_be   = 4'h0;
        m_wd   = 32'h0;
        for (int j = 0; j < 4; j++) begin
            if (j >= m_off && j < m_off + m_sz) m_be[j] = 1'b1;
            m_wd[8*j +: 8] = m_wdata[8*(j % m_sz) +: 8];
        end
        v = 32'h0;
        for (int i = 0; i < m_sz; i++) v[8*i +: 8] = ref_mem[m_word*4 + m_off + i];
        if (!f[2] && m_sz < 4 && v[8*m_sz-1]) begin
            for (int i = m_sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        m_rdata = (m_write || m_err) ? 32'h0 : v;
        m_lat   = m_err ? 1 : (m_write ? 2 : 3);
        m_busy  = 1'b1;
        m_age   = 1;
    endtask

    initial begin
        m_busy = 1'b0;
        m_age  = 0;
        m_lat  = 1;
        forever begin
            @(posedge clk);
            if (mem_clear) begin
                for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
            end
            if (reset) begin
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (bus.req_valid) model_accept();
            end else if (m_age >= m_lat) begin
                if (bus.resp_ready) m_busy = 1'b0;
            end else begin
                if (m_age == 1 && m_write && !m_err) begin
                    for (int i = 0; i < m_sz; i++) begin
                        ref_mem[m_word*4 + m_off + i] = m_wdata[8*i +: 8];
                    end
                end
                m_age++;
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        bit exp_valid, issue;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_valid = m_busy && (m_age >= m_lat);
                issue     = m_busy && (m_age == 1) && !m_err;
                check("req_ready", {31'b0, bus.req_ready}, {31'b0, !m_busy});
                check("resp_valid", {31'b0, bus.resp_valid}, {31'b0, exp_valid});
                if (exp_valid) begin
                    check("resp_rdata", bus.resp_rdata, m_rdata);
                    check("resp_error", {31'b0, bus.resp_error}, {31'b0, m_err});
                end
                check("mem_we", {31'b0, bus.mem_we}, {31'b0, issue && m_write && !reset});
                check("mem_be", {28'b0, bus.mem_byteEnable}, {28'b0, issue ? m_be : 4'h0});
                if (issue) begin
                    check("mem_address", {24'b0, bus.mem_address}, {24'b0, m_addr});
                    if (m_write) check("mem_wd", bus.mem_wd, m_wd);
                end
            end
        end
    end

    task automatic drive_req(input bit w, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] d);
        int t;
        t = 0;
        while (!bus.req_ready && t < 20) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("ready_timeout", {31'b0, bus.req_ready}, 32'h1);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f;
        bus.req_addr   = a;
        bus.req_wdata  = d;
    endtask

    task automatic xact(input bit w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input int hold,
                        output logic [31:0] rdata, output logic err, output logic [3:0] be,
                        output logic [31:0] wd, output logic [7:0] ma, output int lat);
        drive_req(w, f, a, d);
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
        be  = bus.mem_byteEnable;
        wd  = bus.mem_wd;
        ma  = bus.mem_address;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk);
            #2;
            lat++;
        end
        check("resp_timeout", {31'b0, bus.resp_valid}, 32'h1);
        rdata = bus.resp_rdata;
        err   = bus.resp_error;
        repeat (hold) begin
            @(posedge clk);
            #2;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #2;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, wd;
        logic        er;
        logic [3:0]  be;
        logic [7:0]  ma;
        int          lat;

        n_tests        = 0;
        n_fail         = 0;
        chk_en         = 1'b0;
        reset          = 1'b1;
        mem_clear      = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset     = 1'b0;
        mem_clear = 1'b0;

        check("rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        check("rst_resp_error", {31'b0, bus.resp_error}, 32'h0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        check("rst_mem_be", {28'b0, bus.mem_byteEnable}, 32'h0);
        check("rst_mem_address", {24'b0, bus.mem_address}, 32'h0);
        check("rst_mem_wd", bus.mem_wd, 32'h0);
        chk_en = 1'b1;

        // SW / LW word
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, be, wd, ma, lat);
        check("sw_be", {28'b0, be}, 32'hF);
        check("sw_addr", {24'b0, ma}, 32'h04);
        check("sw_wd", wd, 32'hDEADBEEF);
        check("sw_lat", lat, 2);
        xact(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, be, wd, ma, lat);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_be", {28'b0, be}, 32'hF);
        check("lw_lat", lat, 3);

        // SB / LB / LBU
        xact(1'b1, 3'b000, 32'h13, 32'h00000080, 0, rd, er, be, wd, ma, lat);
        check("sb_be", {28'b0, be}, 32'h8);
        check("sb_wd", wd, 32'h80808080);
        xact(1'b0, 3'b000, 32'h13, 32'h0, 0, rd, er, be, wd, ma, lat);
        check("lb_rdata", rd, 32'hFFFFFF80);
        xact(1'b0, 3'b100, 32'h13, 32'h0, 0, rd, er, be, wd, ma, lat);
        check("lbu_rdata", rd, 32'h00000080);

        // SH / LH / LHU
        xact(1'b1, 3'b001, 32'h22, 32'h00008001, 0, rd, er, be, wd, ma, lat);
        check("sh_be", {28'b0, be}, 32'hC);
        check("sh_wd", wd, 32'h80018001);
        check("sh_addr", {24'b0, ma}, 32'h08);
        xact(1'b0, 3'b001, 32'h22, 32'h0, 0, rd, er, be, wd, ma, lat);
        check("lh_rdata", rd, 32'hFFFF8001);
        xact(1'b0, 3'b101, 32'h22, 32'h0, 0, rd, er, be, wd, ma, lat);
        check("lhu_rdata", rd, 32'h00008001);

        // More lanes of word 4 (now 0x80ADBEEF)
        xact(1'b0, 3'b001, 32'h12, 32'h0, 0, rd, er, be, wd, ma, lat);
        check("lh_hi_rdata", rd, 32'hFFFF80AD);
        xact(1'b0, 3'b000, 32'h10, 32'h0, 0, rd, er, be, wd, ma, lat);
        check("lb_lo_rdata", rd, 32'hFFFFFFEF);
        xact(1'b0, 3'b100, 32'h11, 32'h0, 0, rd, er, be, wd, ma, lat);
        check("lbu_b1_rdata", rd, 32'h000000BE);

        // Misaligned LW
        xact(1'b0, 3'b010, 32'h11, 32'h0, 0, rd, er, be, wd, ma, lat);
`ifdef MISALIGN_TRAP_EN
        check("lw_mis_error", {31'b0, er}, 32'h1);
        check("lw_mis_lat", lat, 1);
        check("lw_mis_rdata", rd, 32'h0);
`else
        check("lw_mis_error", {31'b0, er}, 32'h0);
        check("lw_mis_addr", {24'b0, ma}, 32'h04);
        check("lw_mis_rdata", rd, 32'h80ADBEEF);
`endif
        // Misaligned SH: trapped, or snapped to 0x20 and checked by the model
        xact(1'b1, 3'b001, 32'h21, 32'h00001234, 0, rd, er, be, wd, ma, lat);
        xact(1'b0, 3'b101, 32'h20, 32'h0, 0, rd, er, be, wd, ma, lat);

        // Illegal funct3
        xact(1'b0, 3'b011, 32'h0, 32'h0, 0, rd, er, be, wd, ma, lat);
        check("ill_ld_error", {31'b0, er}, 32'h1);
        check("ill_ld_lat", lat, 1);
        xact(1'b1, 3'b100, 32'h10, 32'h55555555, 0, rd, er, be, wd, ma, lat);
        check("ill_st_error", {31'b0, er}, 32'h1);
        check("ill_st_be", {28'b0, be}, 32'h0);

        // Address wrap beyond ADDR_WIDTH
        xact(1'b1, 3'b010, 32'h404, 32'hCAFEF00D, 0, rd, er, be, wd, ma, lat);
        check("wrap_addr", {24'b0, ma}, 32'h01);
        xact(1'b0, 3'b010, 32'h004, 32'h0, 0, rd, er, be, wd, ma, lat);
        check("wrap_rdata", rd, 32'hCAFEF00D);

        // Reset during store ISSUE: not committed
        drive_req(1'b1, 3'b010, 32'h10, 32'h12345678);
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
        check("sw_issue_we", {31'b0, bus.mem_we}, 32'h1);
        reset = 1'b1;
        #1;
        check("sw_rst_we_forced", {31'b0, bus.mem_we}, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        xact(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, be, wd, ma, lat);
        check("sw_rst_not_committed", rd, 32'h80ADBEEF);

        // Reset during load CAPTURE: response dropped
        drive_req(1'b0, 3'b010, 32'h10, 32'h0);
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        check("cap_rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        check("cap_rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
        check("cap_rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        bus.resp_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #2;
            check("cap_rst_no_resp", {31'b0, bus.resp_valid}, 32'h0);
        end
        bus.resp_ready = 1'b0;

        // Back-pressure: resp_ready low 5 cycles
        xact(1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er, be, wd, ma, lat);
        check("bp_rdata", rd, 32'h80ADBEEF);
        check("bp_idle_after", {31'b0, bus.req_ready}, 32'h1);

        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
